// File: rtl/div_radix2.sv
// Radix-2 restoring divider for DIV/DIVU: 33 cycles from accept to ready (2 for a zero divisor).
// The result and ready are held while start stays high and clear once start drops.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [64:0] work;
  logic [31:0] div_abs;
  logic        neg_q, neg_r;

  logic [31:0] abs1, abs2;
  logic [32:0] diff;
  logic [64:0] work_step;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    abs1 = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
    abs2 = (signed_div && opdata2[31]) ? -opdata2 : opdata2;
    // diff[32] is a reliable sign bit: the window only exceeds 2^32 when it is at least the divisor
    diff = work[64:32] - {1'b0, div_abs};
    work_step = diff[32] ? {work[63:0], 1'b0} : {diff[31:0], work[31:0], 1'b1};
    quo_fix = neg_q ? -work_step[31:0]  : work_step[31:0];
    rem_fix = neg_r ? -work_step[64:33] : work_step[64:33];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !annul) state_nxt = (opdata2 == 32'd0) ? BYZERO : ON;
      BYZERO:  state_nxt = END;
      ON: begin
        if (annul)             state_nxt = IDLE;
        else if (cnt == 6'd31) state_nxt = END;
      end
      END:     if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 6'd0;
      work    <= 65'd0;
      div_abs <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= 64'd0;
      ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result <= 64'd0;
          ready  <= 1'b0;
          if (start && !annul && opdata2 != 32'd0) begin
            cnt     <= 6'd0;
            work    <= {32'd0, abs1, 1'b0};
            div_abs <= abs2;
            neg_q   <= signed_div & (opdata1[31] ^ opdata2[31]);
            neg_r   <= signed_div & opdata1[31];
          end
        end
        BYZERO: begin
          result <= 64'd0;
          ready  <= 1'b1;
        end
        ON: begin
          if (annul) begin
            cnt    <= 6'd0;
            result <= 64'd0;
            ready  <= 1'b0;
          end else begin
            work <= work_step;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              result <= {rem_fix, quo_fix};
              ready  <= 1'b1;
            end
          end
        end
        END: begin
          if (!start) begin
            result <= 64'd0;
            ready  <= 1'b0;
          end
        end
        default: begin
          result <= 64'd0;
          ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2: latency, signed/unsigned results, zero divisor, annul, reset mid-op.
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1, opdata2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  div_radix2 dut (
    .clk       (clk),
    .rst       (rst),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .start     (start),
    .annul     (annul),
    .result    (result),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns edges counted until ready is seen; 100 means it never came.
  task automatic wait_ready(output int n);
    n = 100;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [63:0] exp_res);
    int n;
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    tick();
    n = 1;
    // operands changing after acceptance must not disturb the result
    signed_div = ~sd;
    opdata1    = ~a;
    opdata2    = 32'd0;
    if (!ready) begin
      wait_ready(n);
      n = n + 1;
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    start = 1'b0;
    tick();
    check({tag, " ready drop"}, 64'(ready), 64'd0);
    check({tag, " result clear"}, result, 64'd0);
  endtask

  initial begin
    int n;
    logic seen_ready;
    rst        = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    start      = 1'b0;
    annul      = 1'b0;
    tick();
    tick();
    check("reset ready", 64'(ready), 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b0;
    tick();

    run_div("u 100/7",        1'b0, 32'd100,        32'd7,          33, 64'h00000002_0000000E);
    run_div("s -7/2",         1'b1, 32'hFFFFFFF9,   32'd2,          33, 64'hFFFFFFFF_FFFFFFFD);
    run_div("s 7/-2",         1'b1, 32'd7,          32'hFFFFFFFE,   33, 64'h00000001_FFFFFFFD);
    run_div("s min/-1",       1'b1, 32'h80000000,   32'hFFFFFFFF,   33, 64'h00000000_80000000);
    run_div("u max/1",        1'b0, 32'hFFFFFFFF,   32'd1,          33, 64'h00000000_FFFFFFFF);
    run_div("u 5/9",          1'b0, 32'd5,          32'd9,          33, 64'h00000005_00000000);
    run_div("u 1234/0",       1'b0, 32'd1234,       32'd0,           2, 64'd0);
    run_div("u 9/3",          1'b0, 32'd9,          32'd3,          33, 64'h00000000_00000003);

    // annul in cycle t+10 of a running division
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = 1'b1;
    repeat (10) tick();
    annul = 1'b1;
    start = 1'b0;
    tick();
    annul = 1'b0;
    seen_ready = ready;
    repeat (40) begin
      tick();
      seen_ready = seen_ready | ready;
    end
    check("annul no ready", 64'(seen_ready), 64'd0);
    check("annul result", result, 64'd0);
    run_div("u 50/5",         1'b0, 32'd50,         32'd5,          33, 64'h00000000_0000000A);

    // reset during ON with start held high restarts a full division
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid ready", 64'(ready), 64'd0);
    check("rst mid result", result, 64'd0);
    wait_ready(n);
    check("rst restart latency", 64'(n), 64'd33);
    check("rst restart result", result, 64'h00000002_0000000E);
    repeat (3) begin
      tick();
      check("end hold ready", 64'(ready), 64'd1);
      check("end hold result", result, 64'h00000002_0000000E);
    end
    start = 1'b0;
    tick();
    check("end release ready", 64'(ready), 64'd0);
    check("end release result", result, 64'd0);

    // start and annul together in IDLE are ignored
    opdata1 = 32'd9;
    opdata2 = 32'd0;
    start   = 1'b1;
    annul   = 1'b1;
    repeat (5) tick();
    check("start+annul ignored", 64'(ready), 64'd0);
    start = 1'b0;
    annul = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_radix2.md
# div_radix2

Multi-cycle radix-2 restoring divider that executes DIV and DIVU for the execute stage. The ALU drives the operands, signedness and start. It holds its stall request until `ready` rises, then captures `result` straight into its HI/LO write path. Port order is fixed as listed so the execute stage can bind it positionally.

## Interface
- No parameters; data width fixed at 32-bit operands and a 64-bit result.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `opdata1`  in  32  dividend; sampled with `start`.
- `opdata2`  in  32  divisor; sampled with `start`.
- `start`  in  1  request; level-sensitive, held high by the ALU until `ready`.
- `annul`  in  1  abort in-flight division (exception/flush); tied 0 by the current ALU.
- `result`  out  64  {remainder[63:32], quotient[31:0]} = {HI, LO}; registered.
- `ready`  out  1  result valid; registered.

## Operation
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - `start`=1 & `annul`=0 & `opdata2`==0 → BYZERO.
  - `start`=1 & `annul`=0 & `opdata2`!=0 → ON. Latch operands and signedness. Clear the 6-bit iteration counter. Load the 65-bit work register with {32'b0, |dividend|, 1'b0}.
  - Otherwise stay; `ready`=0, `result`=0.
- Magnitudes: when `signed_div`=1, negative operands are two's-complement negated. 0x80000000 maps to 0x80000000, treated as unsigned 2^31. When `signed_div`=0, operands are used as-is.
- ON, per cycle:
  - Trial-subtract `work[64:32]` minus {1'b0, |divisor|}.
  - Non-negative difference: shift the difference into the upper half and shift 1 into the quotient LSB.
  - Negative difference: plain left shift, quotient bit 0.
  - Counter increments; after the 32nd iteration → END.
  - `annul`=1 in ON → IDLE next edge; `ready` and `result` stay 0.
- Sign fix-up, applied on the transition into END:
  - Quotient is negated iff `signed_div` & (dividend[31] ^ divisor[31]).
  - Remainder is negated iff `signed_div` & dividend[31]; it takes the sign of the dividend.
- BYZERO: `result` := 0 → END. MIPS leaves the result undefined; this block defines it as 0.
- END:
  - `ready`=1 and `result` are valid.
  - `start`=0 → IDLE next edge, `ready`:=0, `result`:=0.
  - `start`=1 → hold END with the same result.
- Operand or `signed_div` changes after sampling are ignored until the next IDLE.
- Deasserting `start` during ON or BYZERO does not abort; only `annul` or `rst` do.
- 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000 and remainder 0; no trap.

## Timing
- Reset: state IDLE, counter 0, `result`=0, `ready`=0. Takes effect at the next edge from any state, including mid-ON, and discards the work.
- Start accepted at edge of cycle t (IDLE, `start`=1).
- Nonzero divisor: ON for cycles t+1..t+32, END at t+33 → `ready` high in cycle t+33. Latency 33 cycles from accept to `ready`.
- Zero divisor: BYZERO at t+1, `ready` high at t+2.
- Handshake:
  - The ALU deasserts `start` combinationally in the cycle `ready`=1.
  - The divider returns to IDLE at the next edge, so `ready` is a one-cycle pulse under normal use.
  - A back-to-back division can be accepted in the cycle after that return, earliest t+34 start-accept.
- `start` & `annul` both 1 in IDLE: request ignored.

## Test plan
- Unsigned: `signed_div`=0, 100 / 7, start at t → `ready`=1 exactly at t+33, `result`=0x00000002_0000000E; `ready` drops the cycle after `start` falls.
- Signed, mixed signs: -7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Boundary operands:
  - Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
  - Unsigned 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
  - Unsigned 5 / 9 → 0x00000005_00000000.
- Divide by zero: 1234 / 0 → `ready` at t+2, `result`=0. Then an immediate second division 9/3 completes with 0x00000000_00000003.
- Abort: `annul`=1 at t+10 → IDLE at t+11, `ready` never asserts. A following 50/5 completes correctly.
- Reset mid-op: `rst`=1 at t+20 for one cycle → `ready`=0, `result`=0 next cycle. `start` held high through reset restarts a full 33-cycle division after release. Holding `start` high in END keeps `ready`=1 with a stable `result`.
